// File: rtl/daq_control_mc_if.sv
// Controller-to-readout-chain bundle: per-chain readout start/done handshake and chip-full flags.
interface daq_control_mc_if #(
  parameter int CHAIN_NUM = 4
);
  logic [CHAIN_NUM-1:0] StartReadout;
  logic [CHAIN_NUM-1:0] EndReadout;
  logic [CHAIN_NUM-1:0] CHIPSATB;

  modport master (output StartReadout, input EndReadout, input CHIPSATB);
  modport slave  (input StartReadout, output EndReadout, output CHIPSATB);
endinterface

// File: rtl/daq_control_mc.sv
// Multi-chain DAQ sequencer: power, ASIC reset, acquisition, hold and serial per-chain readout.
// All outputs registered (one cycle from decision); chains answer StartReadout with EndReadout or time out.
module daq_control_mc #(
  parameter int CHAIN_NUM       = 4,
  parameter int TIME_WIDTH      = 16,
  parameter int CNT_WIDTH       = 16,
  parameter int RESET_CYCLES    = 4,
  parameter int READOUT_TIMEOUT = 65535
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  input  logic [1:0]            DaqMode,
  input  logic                  UsbAcqStart,
  input  logic [CHAIN_NUM-1:0]  ChainEnable,
  input  logic [TIME_WIDTH-1:0] AcquisitionTime,
  input  logic [TIME_WIDTH-1:0] EndHoldTime,
  input  logic [TIME_WIDTH-1:0] PwrSettleTime,
  input  logic [CNT_WIDTH-1:0]  AcqCountTarget,
  input  logic                  ExternalTrigger,
  input  logic                  DataTransmitDone,
  daq_control_mc_if.master      chain,
  output logic                  RESET_B,
  output logic                  START_ACQ,
  output logic                  PWR_ON,
  output logic                  OnceEnd,
  output logic                  AllDone,
  output logic [CNT_WIDTH-1:0]  AcqCount,
  output logic                  ReadoutError,
  output logic                  Busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_POWER, S_RESET, S_ACQ, S_HOLD, S_READOUT, S_ONCE, S_DONE
  } state_t;

  state_t               state_q;
  logic [31:0]          cnt_q;
  logic [CHAIN_NUM-1:0] en_q, act_q, start_readout_q;
  logic                 reset_b_q, start_acq_q, pwr_on_q, once_end_q, all_done_q;
  logic                 readout_error_q, busy_q;
  logic [CNT_WIDTH-1:0] acq_count_q;
  logic [1:0]           trig_sync_q;
  logic                 trig_prev_q;

  logic [31:0]           cnt_d;
  logic [TIME_WIDTH-1:0] settle_lim, acq_lim, hold_lim;
  logic [CNT_WIDTH-1:0]  target_lim, acq_count_d;
  logic [CHAIN_NUM-1:0]  first_act_d, rem_d, next_act_d;
  logic                  trig_edge, chip_full, trig_mode, counted_mode, end_hit, ro_timeout;

  assign cnt_d        = cnt_q + 32'd1;
  assign settle_lim   = (PwrSettleTime   == '0) ? TIME_WIDTH'(1) : PwrSettleTime;
  assign acq_lim      = (AcquisitionTime == '0) ? TIME_WIDTH'(1) : AcquisitionTime;
  assign hold_lim     = (EndHoldTime     == '0) ? TIME_WIDTH'(1) : EndHoldTime;
  assign target_lim   = (AcqCountTarget  == '0) ? CNT_WIDTH'(1)  : AcqCountTarget;
  assign acq_count_d  = (acq_count_q == '1) ? acq_count_q : acq_count_q + CNT_WIDTH'(1);
  assign trig_mode    = (DaqMode == 2'd1);
  assign counted_mode = (DaqMode == 2'd2);
  assign trig_edge    = trig_sync_q[1] & ~trig_prev_q;
  assign chip_full    = |(ChainEnable & ~chain.CHIPSATB);
  assign end_hit      = |(chain.EndReadout & act_q);
  assign ro_timeout   = (cnt_q == 32'(READOUT_TIMEOUT - 1));

  // One-hot chain walk: lowest enabled bit overall, and lowest enabled bit above the active one.
  assign first_act_d = ChainEnable & (~ChainEnable + CHAIN_NUM'(1));
  assign rem_d       = en_q & ~((act_q << 1) - CHAIN_NUM'(1));
  assign next_act_d  = rem_d & (~rem_d + CHAIN_NUM'(1));

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_sync_q <= '0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_sync_q <= {trig_sync_q[0], ExternalTrigger};
      trig_prev_q <= trig_sync_q[1];
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      en_q            <= '0;
      act_q           <= '0;
      start_readout_q <= '0;
      reset_b_q       <= 1'b1;
      start_acq_q     <= 1'b0;
      pwr_on_q        <= 1'b0;
      once_end_q      <= 1'b0;
      all_done_q      <= 1'b0;
      acq_count_q     <= '0;
      readout_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      start_readout_q <= '0;
      once_end_q      <= 1'b0;
      case (state_q)
        S_IDLE: if (UsbAcqStart) begin
          state_q         <= S_POWER;
          pwr_on_q        <= 1'b1;
          busy_q          <= 1'b1;
          acq_count_q     <= '0;
          readout_error_q <= 1'b0;
          cnt_q           <= '0;
        end
        S_POWER: if (!UsbAcqStart) begin
          state_q    <= S_DONE;
          all_done_q <= 1'b1;
          pwr_on_q   <= 1'b0;
        end else if (cnt_d >= 32'(settle_lim)) begin
          state_q   <= S_RESET;
          reset_b_q <= 1'b0;
          cnt_q     <= '0;
        end else cnt_q <= cnt_d;
        S_RESET: if (!UsbAcqStart) begin
          state_q    <= S_DONE;
          reset_b_q  <= 1'b1;
          all_done_q <= 1'b1;
          pwr_on_q   <= 1'b0;
        end else if (cnt_q == 32'(RESET_CYCLES - 1)) begin
          state_q     <= S_ACQ;
          reset_b_q   <= 1'b1;
          start_acq_q <= 1'b1;
          cnt_q       <= '0;
        end else cnt_q <= cnt_d;
        // A single exit however many end conditions coincide.
        S_ACQ: if (!UsbAcqStart || chip_full || (trig_mode ? trig_edge : (cnt_d >= 32'(acq_lim)))) begin
          state_q     <= S_HOLD;
          start_acq_q <= 1'b0;
          cnt_q       <= '0;
        end else cnt_q <= cnt_d;
        S_HOLD: if (cnt_d >= 32'(hold_lim)) begin
          en_q  <= ChainEnable;
          cnt_q <= '0;
          if (first_act_d == '0) begin
            state_q     <= S_ONCE;
            once_end_q  <= 1'b1;
            acq_count_q <= acq_count_d;
          end else begin
            state_q         <= S_READOUT;
            act_q           <= first_act_d;
            start_readout_q <= first_act_d;
          end
        end else cnt_q <= cnt_d;
        S_READOUT: if (end_hit || ro_timeout) begin
          if (!end_hit) readout_error_q <= 1'b1;
          cnt_q <= '0;
          if (next_act_d == '0) begin
            state_q     <= S_ONCE;
            once_end_q  <= 1'b1;
            acq_count_q <= acq_count_d;
          end else begin
            act_q           <= next_act_d;
            start_readout_q <= next_act_d;
          end
        end else cnt_q <= cnt_d;
        S_ONCE: if (!UsbAcqStart || (counted_mode && acq_count_q >= target_lim)) begin
          state_q    <= S_DONE;
          all_done_q <= 1'b1;
          pwr_on_q   <= 1'b0;
        end else begin
          state_q   <= S_RESET;
          reset_b_q <= 1'b0;
          cnt_q     <= '0;
        end
        S_DONE: if (DataTransmitDone) begin
          state_q    <= S_IDLE;
          all_done_q <= 1'b0;
          busy_q     <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign chain.StartReadout = start_readout_q;
  assign RESET_B            = reset_b_q;
  assign START_ACQ          = start_acq_q;
  assign PWR_ON             = pwr_on_q;
  assign OnceEnd            = once_end_q;
  assign AllDone            = all_done_q;
  assign AcqCount           = acq_count_q;
  assign ReadoutError       = readout_error_q;
  assign Busy               = busy_q;

endmodule

// File: tb/tb_daq_control_mc.sv
// Directed bench for daq_control_mc: scoreboard of acquisition lengths, readout starts and OnceEnd pulses.
module tb_daq_control_mc;
  localparam int CN = 4;

  logic        Clk = 1'b0;
  logic        reset_n;
  logic [1:0]  DaqMode;
  logic        UsbAcqStart;
  logic [3:0]  ChainEnable;
  logic [15:0] AcquisitionTime, EndHoldTime, PwrSettleTime, AcqCountTarget;
  logic        ExternalTrigger, DataTransmitDone;
  logic        RESET_B, START_ACQ, PWR_ON, OnceEnd, AllDone, ReadoutError, Busy;
  logic [15:0] AcqCount;

  daq_control_mc_if #(.CHAIN_NUM(CN)) chain_if ();

  daq_control_mc #(
    .CHAIN_NUM(CN), .TIME_WIDTH(16), .CNT_WIDTH(16), .RESET_CYCLES(4), .READOUT_TIMEOUT(100)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .DaqMode(DaqMode), .UsbAcqStart(UsbAcqStart),
    .ChainEnable(ChainEnable), .AcquisitionTime(AcquisitionTime), .EndHoldTime(EndHoldTime),
    .PwrSettleTime(PwrSettleTime), .AcqCountTarget(AcqCountTarget),
    .ExternalTrigger(ExternalTrigger), .DataTransmitDone(DataTransmitDone), .chain(chain_if),
    .RESET_B(RESET_B), .START_ACQ(START_ACQ), .PWR_ON(PWR_ON), .OnceEnd(OnceEnd),
    .AllDone(AllDone), .AcqCount(AcqCount), .ReadoutError(ReadoutError), .Busy(Busy)
  );

  // ref_sel: 0 = no timing check, 1 = gap from last StartReadout, 2 = gap from last START_ACQ-high cycle
  typedef struct { int val; int gap; int ref_sel; } ev_t;
  ev_t exp_sr[$];
  ev_t exp_once[$];
  int  exp_acq[$];

  int n_cmp = 0, n_err = 0, cyc = 0;
  int acq_run = 0, last_acq_cyc = 0, last_sr_cyc = 0;
  int lat = 60;
  logic [3:0] resp_en = 4'hF;
  int tmr[CN];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_ev(input string tag, input int val, input bit is_sr);
    ev_t e;
    int  ref_cyc;
    if ((is_sr && exp_sr.size() == 0) || (!is_sr && exp_once.size() == 0)) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_unexpected: observed %0d at cycle %0d, required no event", tag, val, cyc);
    end else begin
      if (is_sr) e = exp_sr.pop_front();
      else       e = exp_once.pop_front();
      chk({tag, "_val"}, val, e.val);
      if (e.ref_sel != 0) begin
        ref_cyc = (e.ref_sel == 1) ? last_sr_cyc : last_acq_cyc;
        chk({tag, "_gap"}, cyc - ref_cyc, e.gap);
      end
    end
  endtask

  // Output monitor: pops the scoreboard whenever the DUT produces an event.
  always @(negedge Clk) begin
    if (START_ACQ === 1'b1) begin
      acq_run++;
      last_acq_cyc = cyc;
    end else if (acq_run > 0) begin
      if (exp_acq.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL acq_unexpected: observed window of %0d cycles, required none", acq_run);
      end else chk("acq_len", acq_run, exp_acq.pop_front());
      acq_run = 0;
    end
    if (chain_if.StartReadout !== 4'b0) begin
      check_ev("sr", int'(chain_if.StartReadout), 1'b1);
      last_sr_cyc = cyc;
    end
    if (OnceEnd === 1'b1) check_ev("once", int'(AcqCount), 1'b0);
  end

  // Readout-engine model: EndReadout[i] lat cycles after StartReadout[i], if that chain responds.
  always @(negedge Clk) begin
    for (int i = 0; i < CN; i++) begin
      if (!reset_n) begin
        tmr[i] = 0;
        chain_if.EndReadout[i] = 1'b0;
      end else if (chain_if.StartReadout[i] && resp_en[i]) begin
        tmr[i] = lat;
        chain_if.EndReadout[i] = 1'b0;
      end else if (tmr[i] > 0) begin
        tmr[i]--;
        chain_if.EndReadout[i] = (tmr[i] == 0);
      end else chain_if.EndReadout[i] = 1'b0;
    end
  end

  function automatic bit cond(input int w);
    case (w)
      0:       return START_ACQ === 1'b1;
      1:       return OnceEnd === 1'b1;
      2:       return AllDone === 1'b1;
      3:       return chain_if.StartReadout !== 4'b0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int w, input int max, output int k);
    k = 0;
    do begin
      @(negedge Clk);
      k++;
    end while (!cond(w) && k < max);
    if (!cond(w)) begin
      n_cmp++;
      n_err++;
      $error("FAIL wait_%0d: not seen within %0d cycles, required seen", w, max);
    end
  endtask

  task automatic end_run(input int exp_cnt);
    int k;
    wait_for(2, 3000, k);
    chk("done_count", AcqCount, exp_cnt);
    chk("done_pwr", PWR_ON, 0);
    chk("done_busy", Busy, 1);
    chk("done_acq", START_ACQ, 0);
    UsbAcqStart = 1'b0;
    repeat (3) @(negedge Clk);
    chk("done_held", AllDone, 1);
    DataTransmitDone = 1'b1;
    @(negedge Clk);
    DataTransmitDone = 1'b0;
    chk("idle_alldone", AllDone, 0);
    chk("idle_busy", Busy, 0);
  endtask

  task automatic push_ev(input bit is_sr, input int val, input int gap, input int ref_sel);
    ev_t e;
    e.val = val; e.gap = gap; e.ref_sel = ref_sel;
    if (is_sr) exp_sr.push_back(e);
    else       exp_once.push_back(e);
  endtask

  initial begin
    int k;
    reset_n = 1'b0;
    DaqMode = 2'd0; UsbAcqStart = 1'b0; ChainEnable = 4'hF;
    AcquisitionTime = 16'd63; EndHoldTime = 16'd20; PwrSettleTime = 16'd10; AcqCountTarget = 16'd0;
    ExternalTrigger = 1'b0; DataTransmitDone = 1'b0; chain_if.CHIPSATB = 4'hF;
    repeat (3) @(negedge Clk);
    chk("rst_sr", chain_if.StartReadout, 0);
    chk("rst_resetb", RESET_B, 1);
    chk("rst_acq", START_ACQ, 0);
    chk("rst_pwr", PWR_ON, 0);
    chk("rst_once", OnceEnd, 0);
    chk("rst_alldone", AllDone, 0);
    chk("rst_count", AcqCount, 0);
    chk("rst_err", ReadoutError, 0);
    chk("rst_busy", Busy, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Auto mode, four chains, two loops with a stop request during the second acquisition.
    exp_acq.push_back(63);
    push_ev(1, 1, 21, 2); push_ev(1, 2, 61, 1); push_ev(1, 4, 61, 1); push_ev(1, 8, 61, 1);
    push_ev(0, 1, 61, 1);
    UsbAcqStart = 1'b1;
    @(negedge Clk);
    chk("power_on", PWR_ON, 1);
    chk("power_busy", Busy, 1);
    wait_for(1, 1000, k);
    push_ev(1, 1, 21, 2); push_ev(1, 2, 61, 1); push_ev(1, 4, 61, 1); push_ev(1, 8, 61, 1);
    push_ev(0, 2, 61, 1);
    wait_for(0, 100, k);
    chk("loop_pwr", PWR_ON, 1);
    repeat (10) @(negedge Clk);
    exp_acq.push_back(11);
    UsbAcqStart = 1'b0;
    end_run(2);

    // Chip full on an enabled chain cuts acquisition; a disabled chain's chip-full is ignored.
    ChainEnable = 4'b1101; chain_if.CHIPSATB = 4'b1101;
    AcquisitionTime = 16'd1000; EndHoldTime = 16'd0;
    push_ev(1, 1, 2, 2); push_ev(1, 4, 61, 1); push_ev(1, 8, 61, 1);
    push_ev(0, 1, 61, 1);
    UsbAcqStart = 1'b1;
    wait_for(0, 100, k);
    repeat (29) @(negedge Clk);
    exp_acq.push_back(30);
    chain_if.CHIPSATB[2] = 1'b0;
    repeat (2) @(negedge Clk);
    chain_if.CHIPSATB = 4'hF;
    UsbAcqStart = 1'b0;
    end_run(1);

    // External trigger ends acquisition; AcquisitionTime ignored; zero settle behaves as one.
    DaqMode = 2'd1; AcquisitionTime = 16'd5; EndHoldTime = 16'd20; PwrSettleTime = 16'd0;
    ChainEnable = 4'b0001;
    UsbAcqStart = 1'b1;
    wait_for(0, 100, k);
    chk("start_to_acq", k, 6);
    repeat (20) @(negedge Clk);
    exp_acq.push_back(23);
    push_ev(1, 1, 21, 2);
    push_ev(0, 1, 61, 1);
    #3 ExternalTrigger = 1'b1;
    repeat (10) @(negedge Clk);
    ExternalTrigger = 1'b0;
    UsbAcqStart = 1'b0;
    end_run(1);

    // Counted mode: three loops then stop on its own with UsbAcqStart still high.
    DaqMode = 2'd2; AcqCountTarget = 16'd3; AcquisitionTime = 16'd8; EndHoldTime = 16'd2;
    PwrSettleTime = 16'd3; ChainEnable = 4'b0010; lat = 5;
    for (int i = 1; i <= 3; i++) begin
      exp_acq.push_back(8);
      push_ev(1, 2, 3, 2);
      push_ev(0, i, 6, 1);
    end
    UsbAcqStart = 1'b1;
    end_run(3);

    // Chain 2 never answers: timeout after 100 cycles, sticky error, OnceEnd still pulses.
    DaqMode = 2'd0; AcquisitionTime = 16'd10; EndHoldTime = 16'd3; ChainEnable = 4'b0101;
    lat = 10; resp_en = 4'b1011;
    exp_acq.push_back(10);
    push_ev(1, 1, 4, 2); push_ev(1, 4, 11, 1);
    push_ev(0, 1, 100, 1);
    UsbAcqStart = 1'b1;
    wait_for(3, 200, k);
    chk("err_before", ReadoutError, 0);
    UsbAcqStart = 1'b0;
    wait_for(1, 300, k);
    chk("err_after", ReadoutError, 1);
    end_run(1);
    chk("err_sticky", ReadoutError, 1);

    // No chains enabled: OnceEnd follows HOLD directly.
    ChainEnable = 4'b0000; EndHoldTime = 16'd5; resp_en = 4'hF;
    exp_acq.push_back(10);
    push_ev(0, 1, 6, 2);
    UsbAcqStart = 1'b1;
    wait_for(0, 100, k);
    chk("err_cleared", ReadoutError, 0);
    wait_for(1, 100, k);
    UsbAcqStart = 1'b0;
    end_run(1);

    // Asynchronous reset in the middle of a readout.
    ChainEnable = 4'b0001; EndHoldTime = 16'd3; lat = 5;
    exp_acq.push_back(10); push_ev(1, 1, 4, 2); push_ev(0, 1, 6, 1);
    UsbAcqStart = 1'b1;
    wait_for(1, 200, k);
    resp_en = 4'b0000;
    exp_acq.push_back(10); push_ev(1, 1, 4, 2);
    wait_for(3, 200, k);
    repeat (3) @(negedge Clk);
    chk("pre_rst_count", AcqCount, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_sr", chain_if.StartReadout, 0);
    chk("arst_resetb", RESET_B, 1);
    chk("arst_acq", START_ACQ, 0);
    chk("arst_pwr", PWR_ON, 0);
    chk("arst_once", OnceEnd, 0);
    chk("arst_alldone", AllDone, 0);
    chk("arst_count", AcqCount, 0);
    chk("arst_err", ReadoutError, 0);
    chk("arst_busy", Busy, 0);
    UsbAcqStart = 1'b0;
    @(negedge Clk);
    reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("post_rst_busy", Busy, 0);
    chk("post_rst_pwr", PWR_ON, 0);

    chk("acq_q_left", exp_acq.size(), 0);
    chk("sr_q_left", exp_sr.size(), 0);
    chk("once_q_left", exp_once.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/daq_control_mc.md
Name: daq_control_mc

Overview:
Multi-chain successor to the single-chain DAQ controller. Sequences power-pulsing, ASIC reset, acquisition, hold and per-chain readout for up to CHAIN_NUM HARDROC readout chains under USB start/stop control. Supports three modes: auto (timed), external-trigger and counted. Sits between the USB command decoder and the per-chain readout engines.

Parameters:
CHAIN_NUM, 4, number of ASIC readout chains
TIME_WIDTH, 16, width of AcquisitionTime, EndHoldTime and PwrSettleTime
CNT_WIDTH, 16, width of AcqCountTarget and AcqCount
RESET_CYCLES, 4, RESET_B low duration in cycles
READOUT_TIMEOUT, 65535, max cycles waiting for EndReadout of one chain

Ports:
Clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
DaqMode  input  2  0=auto, 1=ext trigger, 2=counted (auto timing plus count limit), 3=treated as auto
UsbAcqStart  input  1  level; high=run, low=stop request
ChainEnable  input  CHAIN_NUM  per-chain enable
AcquisitionTime  input  TIME_WIDTH  START_ACQ high duration in cycles
EndHoldTime  input  TIME_WIDTH  cycles between START_ACQ fall and first StartReadout
PwrSettleTime  input  TIME_WIDTH  cycles between PWR_ON rise and RESET_B pulse
AcqCountTarget  input  CNT_WIDTH  acquisitions per run in counted mode
ExternalTrigger  input  1  asynchronous trigger input
CHIPSATB  input  CHAIN_NUM  per-chain chip-full, active low
EndReadout  input  CHAIN_NUM  per-chain 1-cycle readout-done pulse
DataTransmitDone  input  1  USB side drained all data
StartReadout  output  CHAIN_NUM  per-chain 1-cycle readout start pulse
RESET_B  output  1  ASIC reset, active low
START_ACQ  output  1  ASIC acquisition window
PWR_ON  output  1  drives PWR_ON_A/D/ADC/DAC
OnceEnd  output  1  1-cycle pulse per completed acquisition
AllDone  output  1  run finished, held until DataTransmitDone
AcqCount  output  CNT_WIDTH  acquisitions completed in current run
ReadoutError  output  1  sticky; a chain timed out
Busy  output  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; StartReadout=0, RESET_B=1, START_ACQ=0, PWR_ON=0, OnceEnd=0, AllDone=0, AcqCount=0, ReadoutError=0, Busy=0; internal counters cleared. Reset mid-operation aborts immediately.
- ExternalTrigger passes a 2-FF synchronizer; a rising edge is detected on the synchronized signal (3 cycles input-to-event latency).
- IDLE: on UsbAcqStart=1 -> POWER (AcqCount cleared, ReadoutError cleared).
- POWER: PWR_ON=1 from this state until return to IDLE; wait PwrSettleTime cycles (0 treated as 1) -> RESET.
- RESET: RESET_B=0 for exactly RESET_CYCLES cycles -> ACQ.
- ACQ: START_ACQ=1. Exit to HOLD on the first of:
  - any enabled chain CHIPSATB=0 (all modes);
  - auto/counted mode: START_ACQ high for AcquisitionTime cycles (0 treated as 1);
  - trigger mode: trigger edge detected; AcquisitionTime ignored.
  CHIPSATB of disabled chains is ignored.
- HOLD: START_ACQ=0; wait EndHoldTime cycles (0 allowed: 1 cycle in HOLD) -> READOUT at chain 0.
- READOUT: chains serviced in ascending index; disabled chains are skipped at zero cost.
  - Enabled chain i: StartReadout[i] pulsed for 1 cycle, then wait for EndReadout[i].
  - EndReadout arriving in the same cycle as StartReadout is accepted.
  - If READOUT_TIMEOUT cycles elapse without EndReadout: ReadoutError=1 (sticky), advance to next chain.
  - EndReadout on a non-active chain is ignored.
  - ChainEnable sampled on entry to READOUT.
  - After the last chain (or immediately if none enabled) -> ONCE.
- ONCE: OnceEnd=1 for 1 cycle; AcqCount+1 (saturates at all-ones). Next state:
  - UsbAcqStart=0 -> DONE;
  - counted mode and AcqCount+1 >= AcqCountTarget -> DONE (target 0 behaves as 1);
  - otherwise -> RESET (PWR_ON stays high).
- UsbAcqStart falling during POWER/RESET/ACQ: ACQ ends next cycle -> HOLD -> READOUT completes normally; in POWER/RESET go directly to DONE without readout or count.
- DONE: AllDone=1, PWR_ON=0; wait DataTransmitDone=1 -> IDLE (AllDone cleared). DataTransmitDone in other states is ignored.
- Simultaneous chip-full and trigger/timeout in ACQ: single exit, no double count.

Test Plan:
- Auto, CHAIN_NUM=4, ChainEnable=4'b1111, AcquisitionTime=63, EndHoldTime=20, PwrSettleTime=10, no chip full, each EndReadout 60 cycles after its StartReadout -> START_ACQ high 63 cycles; StartReadout[0..3] in order, each 61 cycles apart; OnceEnd per loop; after UsbAcqStart=0, exactly one final readout, then AllDone=1 until DataTransmitDone.
- Chip full: CHIPSATB[2]=0 at cycle 30 of ACQ, AcquisitionTime=1000 -> START_ACQ falls next cycle; CHIPSATB[1]=0 with ChainEnable[1]=0 -> no effect.
- Trigger mode, trigger pulse 100 ns at 1689 ns after start -> START_ACQ falls 3-4 cycles after the edge; AcquisitionTime=5 ignored.
- Counted mode, AcqCountTarget=3, UsbAcqStart held high -> exactly 3 OnceEnd pulses, AcqCount=3, AllDone=1, PWR_ON=0.
- ChainEnable=4'b0101, EndReadout[2] never asserted, READOUT_TIMEOUT=100 -> StartReadout only on chains 0 and 2, ReadoutError=1 after 100 cycles, OnceEnd still pulses; ChainEnable=0 -> no StartReadout, OnceEnd directly after HOLD.
- reset_n low mid-READOUT -> all outputs at reset values within the same cycle; AcqCount=0.
